// File: rtl/dffram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dffram_pkg                                                   |
// | Description : Shared state encoding and lane-merge helper for dffram_nr1w. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dffram_pkg;

    localparam int c_MAX_DW = 256;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Callers widen operands to c_MAX_DW and truncate the result back to DW.
    function automatic logic [c_MAX_DW-1:0] merge(
        input logic [c_MAX_DW-1:0] old_word,
        input logic [c_MAX_DW-1:0] new_word,
        input logic [c_MAX_DW-1:0] mask,
        input int                  lw
    );
        logic [c_MAX_DW-1:0] res;
        res = old_word;
        for (int i = 0; i < c_MAX_DW; i++) begin
            res[i] = mask[i / lw] ? new_word[i] : old_word[i];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffram_rport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dffram_rport                                                 |
// | Description : One read port: word mux, write-through bypass, output hold.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dffram_rport
    import dffram_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int LW    = 4,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_buf,
    input  logic                      bypass_en,
    input  logic [AW-1:0]             r_addr,
    input  logic [AW-1:0]             w_addr,
    input  logic [DW-1:0]             w_data,
    input  logic [DW/LW-1:0]          w_mask,
    input  logic [DEPTH-1:0][DW-1:0]  mem,
    output logic [DW-1:0]             r_data
);

    logic [DW-1:0] w_word;
    logic [DW-1:0] w_cur;
    logic [DW-1:0] r_hold;

    assign w_word = mem[r_addr];

    always_comb begin
        w_cur = w_word;
        if (bypass_en && (r_addr == w_addr)) begin
            w_cur = DW'(merge(c_MAX_DW'(w_word), c_MAX_DW'(w_data),
                              c_MAX_DW'(w_mask), LW));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_cur;
        end
    end

    assign r_data = rd_buf ? r_hold : w_cur;

endmodule
`default_nettype wire

// File: rtl/dffram_nr1w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dffram_nr1w                                                  |
// | Description : DFF register-file RAM, one lane-masked write port, NR reads, |
// |               hardware clear after reset.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dffram_nr1w
    import dffram_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 8,
    parameter int NR = 2,
    parameter int LW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NR-1:0]        cfg_rd_buf,
    input  logic                 cfg_wthru,
    input  logic                 w_en,
    output logic                 w_ready,
    input  logic [AW-1:0]        w_addr,
    input  logic [DW-1:0]        w_data,
    input  logic [DW/LW-1:0]     w_mask,
    input  logic [NR*AW-1:0]     r_addr,
    output logic [NR*DW-1:0]     r_data,
    output logic                 busy
);

    localparam int c_DEPTH = 2**AW;

    logic [c_DEPTH-1:0][DW-1:0] r_mem;
    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [AW-1:0]              r_clr_ctr;
    logic [NR-1:0]              r_rd_buf;
    logic                       r_wthru;
    logic                       w_clr_last;
    logic                       w_accept;
    logic                       w_bypass_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_buf <= cfg_rd_buf;
            r_wthru  <= cfg_wthru;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_clr_last = (r_clr_ctr == AW'(c_DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Reset is folded in so nothing is accepted on the edge that restarts the clear.
    always_comb begin
        busy    = !rst_n || (r_state == ST_CLEAR);
        w_ready = rst_n && (r_state == ST_RUN);
    end

    // The counter wraps on the terminal edge, but the FSM has already left CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_ctr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ctr <= r_clr_ctr + 1'b1;
        end
    end

    assign w_accept    = w_en && w_ready;
    assign w_bypass_en = r_wthru && w_accept;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ctr] <= '0;
            end else if (w_accept) begin
                r_mem[w_addr] <= DW'(merge(c_MAX_DW'(r_mem[w_addr]), c_MAX_DW'(w_data),
                                           c_MAX_DW'(w_mask), LW));
            end
        end
    end

    generate
        for (genvar p = 0; p < NR; p++) begin : g_rport
            dffram_rport #(
                .AW    (AW),
                .DW    (DW),
                .LW    (LW),
                .DEPTH (c_DEPTH)
            ) u_rport (
                .clk       (clk),
                .rst_n     (rst_n),
                .rd_buf    (r_rd_buf[p]),
                .bypass_en (w_bypass_en),
                .r_addr    (r_addr[p*AW +: AW]),
                .w_addr    (w_addr),
                .w_data    (w_data),
                .w_mask    (w_mask),
                .mem       (r_mem),
                .r_data    (r_data[p*DW +: DW])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dffram_nr1w.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dffram_nr1w                                               |
// | Description : Self-checking bench for dffram_nr1w against a word-array model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dffram_nr1w;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int NR    = 2;
    localparam int LW    = 4;
    localparam int LANES = DW / LW;
    localparam int DEPTH = 2**AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     cfg_rd_buf;
    logic              cfg_wthru;
    logic              w_en;
    logic              w_ready;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [LANES-1:0]  w_mask;
    logic [NR*AW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_data;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] prev_cur [NR];
    logic [NR-1:0] exp_rd_buf;
    logic          exp_wthru;

    dffram_nr1w #(.AW(AW), .DW(DW), .NR(NR), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_rd_buf (cfg_rd_buf),
        .cfg_wthru  (cfg_wthru),
        .w_en       (w_en),
        .w_ready    (w_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_mask     (w_mask),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] nw,
                                                 input logic [LANES-1:0] mask);
        logic [DW-1:0] bm;
        bm = '0;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) bm = bm | (DW'((1 << LW) - 1) << (l * LW));
        end
        return (old_w & ~bm) | (nw & bm);
    endfunction

    function automatic logic [DW-1:0] exp_cur(input int p);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = r_addr[p*AW +: AW];
        v = model[a];
        if (exp_wthru && w_en && (a == w_addr)) v = lane_merge(v, w_data, w_mask);
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input int p);
        return exp_rd_buf[p] ? prev_cur[p] : exp_cur(p);
    endfunction

    // One RUN-mode clock cycle, advancing the model alongside the DUT.
    task automatic step();
        logic          acc;
        logic [DW-1:0] cur [NR];
        acc = w_en;
        for (int p = 0; p < NR; p++) cur[p] = exp_cur(p);
        @(posedge clk);
        if (acc) model[w_addr] = lane_merge(model[w_addr], w_data, w_mask);
        prev_cur = cur;
        #1;
    endtask

    task automatic do_reset(input logic [NR-1:0] rdb, input logic wt, input bit drop);
        rst_n = 1'b0; cfg_rd_buf = rdb; cfg_wthru = wt;
        w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0; r_addr = '0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || w_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b w_ready=%b expected busy=1 w_ready=0", busy, w_ready);
        end
        for (int p = 0; p < NR; p++) begin
            if (rdb[p]) begin
                checks++;
                if (r_data[p*DW +: DW] !== '0) begin
                    failures++;
                    $display("FAIL reset_buf%0d: got %h expected 00", p, r_data[p*DW +: DW]);
                end
            end
        end
        rst_n = 1'b1; cfg_rd_buf = ~rdb; cfg_wthru = ~wt;
        exp_rd_buf = rdb; exp_wthru = wt;
        for (int k = 0; k < DEPTH; k++) begin
            if (drop && k == 9) begin
                w_en = 1'b1; w_addr = 5'd3; w_data = 8'hA5; w_mask = 2'b11;
            end
            #2;
            checks++;
            if (busy !== 1'b1 || w_ready !== 1'b0) begin
                failures++;
                $display("FAIL clear_flags cycle %0d: busy=%b w_ready=%b expected 1/0", k, busy, w_ready);
            end
            for (int p = 0; p < NR; p++) begin
                if ((!rdb[p] && k >= 1) || (rdb[p] && k >= 2)) begin
                    checks++;
                    if (r_data[p*DW +: DW] !== '0) begin
                        failures++;
                        $display("FAIL clear_read%0d cycle %0d: got %h expected 00", p, k, r_data[p*DW +: DW]);
                    end
                end
            end
            @(posedge clk); #1;
            w_en = 1'b0;
        end
        #2;
        checks++;
        if (busy !== 1'b0 || w_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_flags: busy=%b w_ready=%b expected 0/1", busy, w_ready);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int p = 0; p < NR; p++) prev_cur[p] = '0;
    endtask

    task automatic test_reset();
        do_reset(2'b00, 1'b0, 1'b1);
        r_addr[0 +: AW] = 5'd3;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h00) begin
            failures++;
            $display("FAIL dropped_write: got %h expected 00", r_data[0 +: DW]);
        end
    endtask

    task automatic test_masked_write();
        w_en = 1'b1; w_addr = 5'd7; w_data = 8'h3C; w_mask = 2'b11; step();
        w_data = 8'hF0; w_mask = 2'b01; step();
        w_en = 1'b0; r_addr[0 +: AW] = 5'd7;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h30) begin
            failures++;
            $display("FAIL masked_write: got %h expected 30", r_data[0 +: DW]);
        end
    endtask

    task automatic test_wthru_off();
        w_en = 1'b1; w_addr = 5'd2; w_data = 8'h11; w_mask = 2'b11; step();
        w_data = 8'h22; r_addr[0 +: AW] = 5'd2;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h11) begin
            failures++;
            $display("FAIL same_cycle_old: got %h expected 11", r_data[0 +: DW]);
        end
        step();
        w_en = 1'b0;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h22) begin
            failures++;
            $display("FAIL next_cycle_new: got %h expected 22", r_data[0 +: DW]);
        end
    endtask

    task automatic test_bypass();
        do_reset(2'b00, 1'b1, 1'b0);
        w_en = 1'b1; w_addr = 5'd4; w_data = 8'h12; w_mask = 2'b11; step();
        w_data = 8'hAB; w_mask = 2'b10; r_addr = {5'd5, 5'd4};
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'hA2 || r_data[DW +: DW] !== 8'h00) begin
            failures++;
            $display("FAIL bypass: got p0=%h p1=%h expected A2/00", r_data[0 +: DW], r_data[DW +: DW]);
        end
        step();
        w_en = 1'b0;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'hA2) begin
            failures++;
            $display("FAIL bypass_stored: got %h expected A2", r_data[0 +: DW]);
        end
    endtask

    task automatic test_buffered();
        do_reset(2'b01, 1'b0, 1'b0);
        w_en = 1'b1; w_addr = 5'd9; w_data = 8'h5E; w_mask = 2'b11; step();
        w_en = 1'b0; r_addr = '0; step();
        r_addr = {5'd9, 5'd9};
        #2;
        checks++;
        if (r_data[DW +: DW] !== 8'h5E || r_data[0 +: DW] !== 8'h00) begin
            failures++;
            $display("FAIL buffered_first: got p0=%h p1=%h expected 00/5E", r_data[0 +: DW], r_data[DW +: DW]);
        end
        step();
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h5E) begin
            failures++;
            $display("FAIL buffered_second: got %h expected 5E", r_data[0 +: DW]);
        end
    endtask

    task automatic test_reset_midrun();
        w_en = 1'b1; w_addr = 5'd31; w_data = 8'h77; w_mask = 2'b11; step();
        w_en = 1'b0; r_addr = {5'd31, 5'd0};
        #2;
        checks++;
        if (r_data[DW +: DW] !== 8'h77) begin
            failures++;
            $display("FAIL midrun_write: got %h expected 77", r_data[DW +: DW]);
        end
        repeat (4) step();
        do_reset(2'b00, 1'b0, 1'b0);
        r_addr[0 +: AW] = 5'd31;
        #2;
        checks++;
        if (r_data[0 +: DW] !== 8'h00) begin
            failures++;
            $display("FAIL midrun_cleared: got %h expected 00", r_data[0 +: DW]);
        end
    endtask

    task automatic test_random(input logic [NR-1:0] rdb, input logic wt, input int n);
        logic [DW-1:0] e;
        do_reset(rdb, wt, 1'b0);
        for (int i = 0; i < n; i++) begin
            w_en   = 1'($urandom_range(0, 1));
            w_addr = AW'($urandom_range(0, 7));
            w_data = DW'($urandom);
            w_mask = LANES'($urandom);
            for (int p = 0; p < NR; p++) begin
                r_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom_range(0, 7));
            end
            #2;
            for (int p = 0; p < NR; p++) begin
                e = exp_rdata(p);
                checks++;
                if (r_data[p*DW +: DW] !== e) begin
                    failures++;
                    $display("FAIL random_read%0d iter %0d: got %h expected %h", p, i, r_data[p*DW +: DW], e);
                end
            end
            step();
        end
        w_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_wthru_off();
        test_bypass();
        test_buffered();
        test_reset_midrun();
        test_random(2'b10, 1'b1, 300);
        test_random(2'b01, 1'b0, 300);
        test_random(2'b11, 1'b1, 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
